// File: rtl/nn_uart_pkg.sv
// Shared UART definitions for the NN result path: byte FSM states, ASCII codes and the default
// bit period used by both the image-receive and result-transmit UARTs.
package nn_uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 4;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } byte_state_e;

  // Classifier digits outside 0..9 are reported as '?'.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
    logic [7:0] ascii;
    if (digit <= 4'd9) ascii = ASCII_ZERO + {4'h0, digit};
    else ascii = ASCII_QMARK;
    return ascii;
  endfunction

endpackage

// File: rtl/nn_result_uart_tx_if.sv
// Valid/ready result handshake between the NN core (master) and the result UART (slave).
interface nn_result_uart_tx_if;

  logic       result_valid;
  logic [3:0] result_digit;
  logic       result_ready;

  modport master (
    output result_valid,
    output result_digit,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result_digit,
    output result_ready
  );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 (or 8N2) byte serialiser. A start pulse latches the byte; done is high during the last
// stop cycle, where a new start chains the next byte with no idle gap.
module uart_tx_byte
  import nn_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  byte_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            stop_q, stop_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    stop_d  = stop_q;
    done    = 1'b0;
    tx      = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StStart;
          cnt_d   = '0;
          data_d  = data;
        end
      end
      StStart: begin
        tx = 1'b0;
        if (bit_end) begin
          state_d = StData;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        tx = data_q[bit_q];
        if (bit_end) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            stop_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            done = 1'b1;
            if (start) begin
              state_d = StStart;
              data_d  = data;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: rtl/nn_result_uart_tx.sv
// Sends the classifier digit to the host as ASCII over UART. Define NN_RESULT_CRLF_EN to follow
// the digit with CR LF; otherwise the message is the single digit character.
module nn_result_uart_tx
  import nn_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                reset,
  nn_result_uart_tx_if.slave  res,
  output logic                tx,
  output logic                tx_busy,
  output logic                frame_done
);

`ifdef NN_RESULT_CRLF_EN
  localparam int unsigned NumBytes = 3;
`else
  localparam int unsigned NumBytes = 1;
`endif

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:0] idx_q, idx_d;
  logic       accept;
  logic       byte_start;
  logic       byte_done;
  logic [7:0] byte_data;

  assign res.result_ready = ~busy_q;
  assign accept           = res.result_valid & ~busy_q;
  assign tx_busy          = busy_q;
  assign frame_done       = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      idx_q  <= idx_d;
    end
  end

  // The digit is encoded straight into the byte serialiser, which holds it for the whole byte.
  always_comb begin
    busy_d     = busy_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    byte_start = 1'b0;
    byte_data  = digit_to_ascii(res.result_digit);
    if (accept) begin
      busy_d     = 1'b1;
      idx_d      = '0;
      byte_start = 1'b1;
    end else if (busy_q && byte_done) begin
      if (idx_q == 2'(NumBytes - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        idx_d      = idx_q + 2'd1;
        byte_start = 1'b1;
        byte_data  = (idx_q == 2'd0) ? ASCII_CR : ASCII_LF;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .STOP_BITS    (STOP_BITS)
  ) u_byte (
    .clk   (clk),
    .reset (reset),
    .start (byte_start),
    .data  (byte_data),
    .done  (byte_done),
    .tx    (tx)
  );

endmodule

// File: tb/tb_nn_result_uart_tx.sv
// Self-checking bench for nn_result_uart_tx: a tx line receiver decodes each byte and compares it
// against a queue of expected bytes pushed at the time each digit is offered.
`timescale 1ns/1ps
module tb_nn_result_uart_tx;

`ifdef NN_RESULT_CRLF_EN
  localparam int NumBytes = 3;
`else
  localparam int NumBytes = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  logic tx, tx_busy, frame_done;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fd_count = 0;
  logic [7:0] exp_q[$];

  nn_result_uart_tx_if rif ();

  nn_result_uart_tx #(
    .CLKS_PER_BIT (4),
    .STOP_BITS    (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .res        (rif),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) fd_count++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout need $finish");
    $fatal(1);
  end

  task automatic push_msg(input logic [3:0] d);
    logic [7:0] c;
    c = (d < 4'd10) ? (8'd48 + {4'd0, d}) : 8'd63;
    exp_q.push_back(c);
`ifdef NN_RESULT_CRLF_EN
    exp_q.push_back(8'd13);
    exp_q.push_back(8'd10);
`endif
  endtask

  // Called at a negedge; returns at the negedge of the last stop cycle of the byte.
  task automatic rx_byte(output logic [7:0] b, output int waited, output bit ok);
    b = 8'h00;
    waited = 0;
    ok = 1'b1;
    while (tx !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      repeat (4) @(negedge clk);
      b[k] = tx;
    end
    repeat (4) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rif.result_valid = 1'b0;
    rif.result_digit = 4'd0;
    repeat (2) @(negedge clk);
    n_cmp += 4;
    if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b need 1", tx); end
    if (rif.result_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b need 1", rif.result_ready);
    end
    if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b need 0", tx_busy); end
    if (frame_done !== 1'b0) begin
      n_bad++; $display("FAIL reset_frame_done: got %b need 0", frame_done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_digits();
    logic [3:0] digits[4] = '{4'd4, 4'd12, 4'd9, 4'd0};
    logic [7:0] b, e;
    int w, fd0;
    bit ok;
    foreach (digits[j]) begin
      rif.result_valid = 1'b1;
      rif.result_digit = digits[j];
      push_msg(digits[j]);
      fd0 = fd_count;
      @(negedge clk);
      rif.result_valid = 1'b0;
      n_cmp++;
      if (tx_busy !== 1'b1 || rif.result_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL digit_accept d=%0d: got busy=%b ready=%b need busy=1 ready=0",
                 digits[j], tx_busy, rif.result_ready);
      end
      for (int i = 0; i < NumBytes; i++) begin
        e = exp_q.pop_front();
        rx_byte(b, w, ok);
        n_cmp++;
        if (b !== e || !ok || w != 0) begin
          n_bad++;
          $display("FAIL digit_byte d=%0d #%0d: got %h framing=%0b gap=%0d need %h framing=1 gap=0",
                   digits[j], i, b, ok, w, e);
        end
      end
      n_cmp++;
      if (frame_done !== 1'b0) begin
        n_bad++; $display("FAIL digit_early_done d=%0d: got %b need 0", digits[j], frame_done);
      end
      @(negedge clk);
      n_cmp++;
      if (frame_done !== 1'b1 || rif.result_ready !== 1'b1 || tx_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL digit_done_cycle d=%0d: got done=%b ready=%b busy=%b need 1 1 0",
                 digits[j], frame_done, rif.result_ready, tx_busy);
      end
      @(negedge clk);
      n_cmp++;
      if (frame_done !== 1'b0 || fd_count - fd0 != 1) begin
        n_bad++;
        $display("FAIL digit_done_pulse d=%0d: got done=%b pulses=%0d need 0 and 1 pulse",
                 digits[j], frame_done, fd_count - fd0);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] b, e;
    int w, lows;
    bit ok;
    rif.result_valid = 1'b1;
    rif.result_digit = 4'd1;
    push_msg(4'd1);
    @(negedge clk);
    rif.result_valid = 1'b0;
    fork
      for (int i = 0; i < NumBytes; i++) begin
        e = exp_q.pop_front();
        rx_byte(b, w, ok);
        n_cmp++;
        if (b !== e || !ok || w != 0) begin
          n_bad++;
          $display("FAIL busy_byte #%0d: got %h framing=%0b gap=%0d need %h framing=1 gap=0",
                   i, b, ok, w, e);
        end
      end
      begin
        repeat (10) @(negedge clk);
        rif.result_valid = 1'b1;
        rif.result_digit = 4'd7;
        @(negedge clk);
        rif.result_valid = 1'b0;
      end
    join
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_cmp++;
    if (lows != 0) begin
      n_bad++; $display("FAIL busy_ignored: got %0d low cycles after frame need 0", lows);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b, e;
    int w, fd0;
    bit ok;
    fd0 = fd_count;
    rif.result_valid = 1'b1;
    rif.result_digit = 4'd3;
    push_msg(4'd3);
    @(negedge clk);
    rif.result_digit = 4'd5;
    push_msg(4'd5);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NumBytes; i++) begin
        e = exp_q.pop_front();
        rx_byte(b, w, ok);
        n_cmp++;
        if (b !== e || !ok || w != 0) begin
          n_bad++;
          $display("FAIL b2b_byte msg%0d #%0d: got %h framing=%0b gap=%0d need %h framing=1 gap=0",
                   m, i, b, ok, w, e);
        end
      end
      @(negedge clk);
      n_cmp++;
      if (frame_done !== 1'b1 || rif.result_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_done msg%0d: got done=%b ready=%b need 1 1", m, frame_done,
                 rif.result_ready);
      end
      @(negedge clk);
      rif.result_valid = 1'b0;
    end
    n_cmp++;
    if (fd_count - fd0 != 2) begin
      n_bad++; $display("FAIL b2b_pulses: got %0d need 2", fd_count - fd0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b, e;
    int w, lows;
    bit ok;
    rif.result_valid = 1'b1;
    rif.result_digit = 4'd6;
    push_msg(4'd6);
    @(negedge clk);
    rif.result_valid = 1'b0;
    repeat (16) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1 || rif.result_ready !== 1'b1 || tx_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got tx=%b ready=%b busy=%b need 1 1 0", tx, rif.result_ready,
               tx_busy);
    end
    reset = 1'b0;
    exp_q.delete();
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_cmp++;
    if (lows != 0) begin
      n_bad++; $display("FAIL reset_no_resume: got %0d low cycles need 0", lows);
    end
    rif.result_valid = 1'b1;
    rif.result_digit = 4'd2;
    push_msg(4'd2);
    @(negedge clk);
    rif.result_valid = 1'b0;
    for (int i = 0; i < NumBytes; i++) begin
      e = exp_q.pop_front();
      rx_byte(b, w, ok);
      n_cmp++;
      if (b !== e || !ok || w != 0) begin
        n_bad++;
        $display("FAIL reset_fresh #%0d: got %h framing=%0b gap=%0d need %h framing=1 gap=0",
                 i, b, ok, w, e);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_bad++; $display("FAIL reset_fresh_done: got %b need 1", frame_done);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_digits();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
